risc1_seq_cpu: RTL and testbench

Parametrised multi-cycle successor to the single-opcode sequencer: fetches instruction words over a one-outstanding read handshake, decodes an 8-bit opcode, and executes on a small register file. It adds immediates, arithmetic, jumps, illegal-opcode trapping and configurable fetch stride. It sits between the testbench clock generator, which watches `stop_clock`, and the memory model driving `mem_ready`/`mem_read_value`.

---
 rtl/risc1_mem_if.sv | 25 ++
 rtl/risc1_seq_cpu.sv | 176 +++++++++++++++++
 tb/tb_risc1_seq_cpu.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/risc1_mem_if.sv
// Read-only instruction/data memory handshake for risc1_seq_cpu.
// One outstanding request: the master holds mem_read/mem_address until it
// samples mem_ready high, then drops mem_read for at least one cycle.
interface risc1_mem_if #(
  parameter int ARCH_SIZE = 16
);
  logic [ARCH_SIZE-1:0] mem_address;
  logic                 mem_read;
  logic                 mem_ready;
  logic [ARCH_SIZE-1:0] mem_read_value;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_ready,
    input  mem_read_value
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_ready,
    output mem_read_value
  );
endinterface

// File: rtl/risc1_seq_cpu.sv
// Multi-cycle sequencer CPU: fetches an instruction word (plus an optional
// immediate word) over risc1_mem_if, then executes it on a small register file.
//
// state   | meaning
// --------+----------------------------------------------------------
// F_ISSUE | drive read request for the instruction word at ip
// F_WAIT  | hold request until mem_ready; latch opcode/rd/rs
// I_ISSUE | drive read request for the immediate word at ip
// I_WAIT  | hold request until mem_ready; latch immediate
// EXEC    | perform the operation, one cycle
// HALTED  | absorbing stop state (HALT or illegal opcode) until reset
module risc1_seq_cpu #(
  parameter int ARCH_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int IP_STEP   = 2,
  parameter int RESET_IP  = 0,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  risc1_mem_if.master          mem,
  output logic                 stop_clock,
  output logic                 error,
  output logic [ARCH_SIZE-1:0] ip,
  input  logic [SEL_W-1:0]     dbg_sel,
  output logic [ARCH_SIZE-1:0] dbg_value
);

  localparam logic [2:0] F_ISSUE = 3'd0;
  localparam logic [2:0] F_WAIT  = 3'd1;
  localparam logic [2:0] I_ISSUE = 3'd2;
  localparam logic [2:0] I_WAIT  = 3'd3;
  localparam logic [2:0] EXEC    = 3'd4;
  localparam logic [2:0] HALTED  = 3'd5;

  localparam logic [7:0] OP_NOOP = 8'd0;
  localparam logic [7:0] OP_HALT = 8'd1;
  localparam logic [7:0] OP_LDI  = 8'd2;
  localparam logic [7:0] OP_ADD  = 8'd3;
  localparam logic [7:0] OP_SUB  = 8'd4;
  localparam logic [7:0] OP_JMP  = 8'd5;
  localparam logic [7:0] OP_JZ   = 8'd6;

  localparam logic [ARCH_SIZE-1:0] STEP     = ARCH_SIZE'(IP_STEP);
  localparam logic [ARCH_SIZE-1:0] START_IP = ARCH_SIZE'(RESET_IP);

  logic [2:0]           state;
  logic [7:0]           opcode;
  logic [SEL_W-1:0]     rd_idx;
  logic [SEL_W-1:0]     rs_idx;
  logic [ARCH_SIZE-1:0] imm;
  logic [ARCH_SIZE-1:0] regs [NUM_REGS];

  logic                 wr_en;
  logic [ARCH_SIZE-1:0] wr_data;
  logic [ARCH_SIZE-1:0] rd_val;
  logic [ARCH_SIZE-1:0] rs_val;
  logic                 fetched_needs_imm;

  assign rd_val    = regs[rd_idx];
  assign rs_val    = regs[rs_idx];
  assign dbg_value = regs[dbg_sel];

  // Decode of the word arriving from memory: does it carry an immediate?
  always_comb begin
    fetched_needs_imm = 1'b0;
    case (mem.mem_read_value[7:0])
      OP_LDI, OP_JMP, OP_JZ: fetched_needs_imm = 1'b1;
      default:               fetched_needs_imm = 1'b0;
    endcase
  end

  // Register-file write port: only LDI/ADD/SUB in EXEC write rd.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (state == EXEC) begin
      case (opcode)
        OP_LDI: begin
          wr_en   = 1'b1;
          wr_data = imm;
        end
        OP_ADD: begin
          wr_en   = 1'b1;
          wr_data = rd_val + rs_val;
        end
        OP_SUB: begin
          wr_en   = 1'b1;
          wr_data = rd_val - rs_val;
        end
        default: begin
          wr_en   = 1'b0;
          wr_data = '0;
        end
      endcase
    end
  end

  // Register file: cleared on reset, written from the EXEC result.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_idx] <= wr_data;
    end
  end

  // Sequencer: fetch handshake, ip update, halt/trap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= F_ISSUE;
      ip              <= START_IP;
      mem.mem_read    <= 1'b0;
      mem.mem_address <= '0;
      stop_clock      <= 1'b0;
      error           <= 1'b0;
      opcode          <= OP_NOOP;
      rd_idx          <= '0;
      rs_idx          <= '0;
      imm             <= '0;
    end else begin
      case (state)
        F_ISSUE: begin
          mem.mem_read    <= 1'b1;
          mem.mem_address <= ip;
          state           <= F_WAIT;
        end
        F_WAIT: begin
          if (mem.mem_ready) begin
            opcode       <= mem.mem_read_value[7:0];
            rd_idx       <= mem.mem_read_value[8 +: SEL_W];
            rs_idx       <= mem.mem_read_value[12 +: SEL_W];
            mem.mem_read <= 1'b0;
            ip           <= ip + STEP;
            state        <= fetched_needs_imm ? I_ISSUE : EXEC;
          end
        end
        I_ISSUE: begin
          mem.mem_read    <= 1'b1;
          mem.mem_address <= ip;
          state           <= I_WAIT;
        end
        I_WAIT: begin
          if (mem.mem_ready) begin
            imm          <= mem.mem_read_value;
            mem.mem_read <= 1'b0;
            ip           <= ip + STEP;
            state        <= EXEC;
          end
        end
        EXEC: begin
          state <= F_ISSUE;
          case (opcode)
            OP_NOOP, OP_LDI, OP_ADD, OP_SUB: ;
            OP_HALT: begin
              stop_clock <= 1'b1;
              state      <= HALTED;
            end
            OP_JMP: ip <= imm;
            OP_JZ: begin
              if (rd_val == '0) ip <= imm;
            end
            default: begin
              stop_clock <= 1'b1;
              error      <= 1'b1;
              state      <= HALTED;
            end
          endcase
        end
        HALTED: state <= HALTED;
        default: state <= F_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_risc1_seq_cpu.sv
// Directed bench for risc1_seq_cpu with a word-addressed memory model that
// inserts a programmable number of wait cycles per read.
module tb_risc1_seq_cpu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stop_clock;
  logic        error;
  logic [15:0] ip;
  logic [1:0]  dbg_sel = 2'd0;
  logic [15:0] dbg_value;

  risc1_mem_if #(.ARCH_SIZE(16)) mem_if ();

  risc1_seq_cpu #(
    .ARCH_SIZE(16),
    .NUM_REGS (4),
    .IP_STEP  (2),
    .RESET_IP (0)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem       (mem_if),
    .stop_clock(stop_clock),
    .error     (error),
    .ip        (ip),
    .dbg_sel   (dbg_sel),
    .dbg_value (dbg_value)
  );

  always #5 clock = ~clock;

  logic [15:0] mem_arr [0:65535];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        stray = 1'b0;

  assign mem_if.mem_read_value = mem_arr[mem_if.mem_address];
  assign mem_if.mem_ready = (mem_if.mem_read && (wcnt == wait_cycles)) || stray;

  always @(posedge clock) begin
    if (mem_if.mem_read && !mem_if.mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Request monitor: record issue addresses, flag address changes mid-request.
  logic [15:0] fetch_q [$];
  logic        prev_read = 1'b0;
  logic [15:0] prev_addr = '0;
  int          viol = 0;

  always @(negedge clock) begin
    if (mem_if.mem_read && !prev_read) fetch_q.push_back(mem_if.mem_address);
    if (mem_if.mem_read && prev_read && mem_if.mem_address != prev_addr) viol++;
    prev_read = mem_if.mem_read;
    prev_addr = mem_if.mem_address;
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_arr[a] = d;
  endtask

  task automatic reset_cpu();
    reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    fetch_q.delete();
    viol = 0;
  endtask

  task automatic run_to_halt(input int budget, output int n);
    n = 0;
    while (!stop_clock && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic peek(input logic [1:0] sel, output logic [15:0] v);
    dbg_sel = sel;
    #1;
    v = dbg_value;
  endtask

  logic [15:0] v;

  initial begin
    // NOOP; HALT with zero-wait memory, plus reset values.
    clear_mem();
    wait_cycles = 0;
    wr(16'h0000, 16'h0000);
    wr(16'h0002, 16'h0001);
    reset_cpu();
    check("rst_ip", ip, 16'h0000);
    check("rst_mem_read", mem_if.mem_read, 1'b0);
    check("rst_mem_address", mem_if.mem_address, 16'h0000);
    check("rst_stop", stop_clock, 1'b0);
    check("rst_error", error, 1'b0);
    run_to_halt(100, cyc);
    check("t1_cycles", cyc, 6);
    check("t1_nfetch", fetch_q.size(), 2);
    if (fetch_q.size() == 2) begin
      check("t1_fetch0", fetch_q[0], 16'h0000);
      check("t1_fetch1", fetch_q[1], 16'h0002);
    end
    check("t1_ip", ip, 16'h0004);
    check("t1_error", error, 1'b0);

    // LDI r0,FFFF; LDI r1,2; ADD r0,r1; HALT
    clear_mem();
    wr(16'h0000, 16'h0002); wr(16'h0002, 16'hFFFF);
    wr(16'h0004, 16'h0102); wr(16'h0006, 16'h0002);
    wr(16'h0008, 16'h1003);
    wr(16'h000A, 16'h0001);
    reset_cpu();
    run_to_halt(200, cyc);
    check("t2_cycles", cyc, 16);
    peek(2'd0, v); check("t2_r0_wrap", v, 16'h0001);
    peek(2'd1, v); check("t2_r1", v, 16'h0002);
    check("t2_ip", ip, 16'h000C);
    reset_cpu();
    peek(2'd0, v); check("t2_r0_after_reset", v, 16'h0000);

    // LDI r1,2; SUB r1,r1; HALT
    clear_mem();
    wr(16'h0000, 16'h0102); wr(16'h0002, 16'h0002);
    wr(16'h0004, 16'h1104);
    wr(16'h0006, 16'h0001);
    reset_cpu();
    run_to_halt(200, cyc);
    peek(2'd1, v); check("t2b_r1_sub_self", v, 16'h0000);
    check("t2b_cycles", cyc, 11);

    // JZ r2(=0),0x20 taken
    clear_mem();
    wr(16'h0000, 16'h0206); wr(16'h0002, 16'h0020);
    wr(16'h0020, 16'h0001);
    reset_cpu();
    run_to_halt(200, cyc);
    check("t3_cycles", cyc, 8);
    check("t3_nfetch", fetch_q.size(), 3);
    if (fetch_q.size() == 3) check("t3_target", fetch_q[2], 16'h0020);
    check("t3_ip", ip, 16'h0022);

    // LDI r2,5; JZ r2,0x20 not taken -> falls to 8
    clear_mem();
    wr(16'h0000, 16'h0202); wr(16'h0002, 16'h0005);
    wr(16'h0004, 16'h0206); wr(16'h0006, 16'h0020);
    wr(16'h0008, 16'h0001);
    wr(16'h0020, 16'h007F);
    reset_cpu();
    run_to_halt(200, cyc);
    check("t3b_cycles", cyc, 13);
    check("t3b_nfetch", fetch_q.size(), 5);
    if (fetch_q.size() == 5) check("t3b_fallthrough", fetch_q[4], 16'h0008);
    check("t3b_ip", ip, 16'h000A);
    check("t3b_error", error, 1'b0);

    // JMP 0xFFFE then ip wraps to 0
    clear_mem();
    wr(16'h0000, 16'h0106); wr(16'h0002, 16'h0010);
    wr(16'h0004, 16'h0001);
    wr(16'h0010, 16'h0102); wr(16'h0012, 16'h0001);
    wr(16'h0014, 16'h0005); wr(16'h0016, 16'hFFFE);
    wr(16'hFFFE, 16'h0000);
    reset_cpu();
    run_to_halt(300, cyc);
    check("t3c_cycles", cyc, 26);
    check("t3c_nfetch", fetch_q.size(), 10);
    if (fetch_q.size() == 10) begin
      check("t3c_jmp_target", fetch_q[6], 16'hFFFE);
      check("t3c_wrap", fetch_q[7], 16'h0000);
    end
    check("t3c_ip", ip, 16'h0006);

    // 3 wait cycles per read, stray mem_ready during first F_ISSUE
    clear_mem();
    wait_cycles = 3;
    wr(16'h0000, 16'h0000);
    wr(16'h0002, 16'h0001);
    reset_cpu();
    stray = 1'b1;
    @(posedge clock); #1;
    stray = 1'b0;
    check("t4_stray_issue", mem_if.mem_read, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("t4_hold_read", mem_if.mem_read, 1'b1);
    check("t4_hold_addr", mem_if.mem_address, 16'h0000);
    run_to_halt(200, cyc);
    check("t4_cycles", cyc + 3, 12);
    check("t4_stable", viol, 0);
    check("t4_nfetch", fetch_q.size(), 2);
    check("t4_ip", ip, 16'h0004);

    // Illegal opcode 0x7F
    clear_mem();
    wait_cycles = 0;
    wr(16'h0000, 16'h007F);
    wr(16'h0002, 16'h0000);
    reset_cpu();
    run_to_halt(100, cyc);
    check("t5_cycles", cyc, 3);
    check("t5_error", error, 1'b1);
    check("t5_stop", stop_clock, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    check("t5_no_more_reads", fetch_q.size(), 1);
    check("t5_read_low", mem_if.mem_read, 1'b0);
    check("t5_ip", ip, 16'h0002);

    // Reset during F_WAIT at ip=6, late mem_ready ignored, refetch from 0
    clear_mem();
    wait_cycles = 3;
    reset_cpu();
    repeat (19) @(posedge clock);
    #1;
    check("t6_wait_addr", mem_if.mem_address, 16'h0006);
    check("t6_wait_read", mem_if.mem_read, 1'b1);
    check("t6_wait_ip", ip, 16'h0006);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("t6_rst_read", mem_if.mem_read, 1'b0);
    check("t6_rst_ip", ip, 16'h0000);
    stray = 1'b1;
    @(posedge clock); #1;
    stray = 1'b0;
    check("t6_refetch_read", mem_if.mem_read, 1'b1);
    check("t6_refetch_addr", mem_if.mem_address, 16'h0000);
    check("t6_ip_after_stray", ip, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
